udp_rx_framer: RTL and testbench
================================

# udp_rx_framer

Serial-to-byte front end for the UDP packet path on the Basys-3. It deserializes the JB UDP bit stream MSB-first into bytes and parses the 8-byte UDP header. It computes the 16-bit ones'-complement checksum on the fly and flags each packet good or bad. Its byte stream and end-of-packet verdict feed the packet processor / FIFO stage directly downstream.

## Interface
- MAX_PAYLOAD, 1472: largest accepted payload in bytes; the length field must be ≤ MAX_PAYLOAD+8.
- i_clk  in  1  system clock; all logic on the rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_frame  in  1  high for the duration of one packet on the serial line.
- i_bit_valid  in  1  strobe; i_bit_data is sampled on edges where i_frame & i_bit_valid.
- i_bit_data  in  1  serial data, MSB of each byte first.
- o_byte  out  8  assembled byte (header bytes included).
- o_byte_valid  out  1  one-cycle strobe per byte.
- o_byte_last  out  1  with o_byte_valid on byte index length-1.
- o_src_port, o_dst_port, o_length, o_rx_checksum  out  16 each  header fields; held until the next packet's field overwrites them.
- o_pkt_done  out  1  one-cycle end-of-packet pulse.
- o_pkt_ok  out  1  verdict; valid with o_pkt_done and held until the next done.
- o_err  out  2  00 none, 01 bad checksum, 10 bad length, 11 truncated; held like o_pkt_ok.

## Operation
- States: IDLE, RECV, CHECK, DRAIN.
- IDLE:
  - i_frame high moves to RECV.
  - A qualified bit in that same cycle is the packet's first bit.
  - Bit count, byte count and accumulator clear on entry.
- RECV, byte assembly:
  - Shift in qualified bits MSB-first.
  - On the 8th bit, present the byte on o_byte/o_byte_valid the next cycle and increment the byte index (16-bit).
- RECV, header capture: bytes 0-7 load src port, dst port, length and checksum, all big-endian.
- RECV, checksum accumulation:
  - Each even/odd byte pair forms a big-endian 16-bit word.
  - Add each word into a 16-bit accumulator with end-around carry: 17-bit add, then fold the carry back in.
  - The checksum field itself is included.
  - For an odd length, the last byte is padded as {byte, 8'h00}.
- RECV, length check at byte 5:
  - A length field < 8 or > MAX_PAYLOAD+8 gives err 10.
  - Go to DRAIN with no further bytes emitted.
- RECV, completion: on byte index length-1, assert o_byte_last and go to CHECK.
- RECV, truncation:
  - If i_frame falls before completion (including a partial byte), set err 11, ok=0, and pulse o_pkt_done the next cycle.
  - Then go to IDLE; the partial byte is not emitted.
- CHECK: one cycle for the final fold, then evaluate:
  - rx checksum == 0x0000 (checksum disabled) gives ok=1, err 00.
  - Otherwise accumulator == 0xFFFF gives ok=1, err 00.
  - Otherwise ok=0, err 01.
  - Pulse o_pkt_done.
  - Go to IDLE if i_frame is low, else DRAIN.
- DRAIN:
  - Ignore all bits until i_frame is low.
  - On a length error, pulse o_pkt_done (ok=0, err 10) in the cycle i_frame is first seen low.
  - Then go to IDLE.
- Bits after completion in the same frame are discarded silently; there is no error.
- Reset mid-packet: all state clears, no o_pkt_done, and the block waits in IDLE.
- If i_frame is already high at reset release, the block enters RECV; the bench must not do this.

## Timing
- Reset values:
  - o_byte, all header outputs and o_err are 0.
  - o_byte_valid, o_byte_last, o_pkt_done and o_pkt_ok are 0.
  - State is IDLE.
- Byte latency: o_byte_valid is high the cycle after the edge that sampled the byte's 8th bit.
- Done latency for a complete packet:
  - The final bit is sampled at edge N.
  - o_byte_last is visible in cycle N+1.
  - o_pkt_done is visible in cycle N+2.
- Truncation: o_pkt_done is visible in the cycle after the first i_frame-low edge.
- Back-to-back frames need ≥1 cycle of i_frame low between them.
- Bit strobes may arrive on consecutive cycles; the block never stalls and has no backpressure.
- Header registers update the cycle the corresponding byte is emitted.

## Test plan
- Even-length good packet:
  - Stimulus: src 0x1234, dst 0x0050, len 0x000A, csum 0x41A4, payload AB CD, bits on every cycle.
  - Required: 10 byte strobes, last on 0xCD, done with ok=1, err 00, o_length=0x000A.
- Odd-length good packet:
  - Stimulus: 12 34 00 50 00 09 42 72 AB, with gaps of 3 cycles between bit strobes.
  - Required: ok=1; pad-byte handling confirmed.
- Bad checksum: same as the first packet but csum 0x41A5. Required: ok=0, err 01.
- Checksum disabled: first packet with csum 0x0000. Required: ok=1, err 00.
- Bad length:
  - Stimulus: length field 0x0004, with i_frame held high 20 more bytes.
  - Required: no byte strobes after byte 5; done with err 10 only after i_frame falls.
- Truncation and reset:
  - Drop i_frame after 6 bytes + 3 bits: required 6 byte strobes, done ok=0, err 11.
  - Separately, pulse i_rst_n low mid-packet: required no done pulse, all outputs 0, and the next good packet passes.

Source files
------------

// File: rtl/udp_rx_framer.sv
// udp_rx_framer
//   Deserializes the UDP bit stream (MSB first) into bytes, captures the
//   8-byte UDP header and checks the 16-bit ones'-complement checksum as the
//   bytes arrive. Each packet ends with a one-cycle done pulse that carries a
//   good/bad verdict and an error code.
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_frame               high for the duration of one packet
//   i_bit_valid           bit strobe, qualified by i_frame
//   i_bit_data            serial data, MSB of each byte first
//   o_byte/_valid/_last   assembled byte stream, last flag on byte length-1
//   o_src_port, o_dst_port, o_length, o_rx_checksum   captured header fields
//   o_pkt_done            one-cycle end-of-packet pulse
//   o_pkt_ok, o_err       verdict (00 ok, 01 checksum, 10 length, 11 truncated)
module udp_rx_framer #(
  parameter int unsigned MAX_PAYLOAD = 1472
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_frame,
  input  logic        i_bit_valid,
  input  logic        i_bit_data,
  output logic [7:0]  o_byte,
  output logic        o_byte_valid,
  output logic        o_byte_last,
  output logic [15:0] o_src_port,
  output logic [15:0] o_dst_port,
  output logic [15:0] o_length,
  output logic [15:0] o_rx_checksum,
  output logic        o_pkt_done,
  output logic        o_pkt_ok,
  output logic [1:0]  o_err
);

  localparam logic [15:0] MAX_LEN = 16'(MAX_PAYLOAD + 32'd8);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_CHECK, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]  shift_q, shift_d;
  logic [15:0] byte_idx_q, byte_idx_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  hi_q, hi_d;
  logic        len_err_q, len_err_d;
  logic [7:0]  byte_q, byte_d;
  logic        byte_valid_q, byte_valid_d;
  logic        byte_last_q, byte_last_d;
  logic [15:0] src_q, src_d, dst_q, dst_d, len_q, len_d, csum_q, csum_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic [1:0]  err_q, err_d;

  logic [7:0]  full_byte;
  logic [15:0] new_len;
  logic        is_last;
  logic [15:0] word;
  logic [16:0] sum17;
  logic [15:0] acc_fold;

  // Byte completed by the bit arriving this cycle (valid only on the 8th bit).
  assign full_byte = {shift_q, i_bit_data};
  // Length field as it stands once byte 5 is added.
  assign new_len   = {len_q[15:8], full_byte};
  // Length is fully known from byte 6 onwards; valid lengths are >= 8.
  assign is_last   = (byte_idx_q >= 16'd6) && (byte_idx_q == len_q - 16'd1);
  // Odd byte closes a big-endian word; a trailing even byte is zero-padded.
  assign word      = byte_idx_q[0] ? {hi_q, full_byte} : {full_byte, 8'h00};
  // End-around carry: the fold can never carry again (max 0xFFFE + 1).
  assign sum17     = {1'b0, acc_q} + {1'b0, word};
  assign acc_fold  = sum17[15:0] + {15'd0, sum17[16]};

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_idx_d   = byte_idx_q;
    acc_d        = acc_q;
    hi_d         = hi_q;
    len_err_d    = len_err_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    byte_last_d  = 1'b0;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    csum_d       = csum_q;
    done_d       = 1'b0;
    ok_d         = ok_q;
    err_d        = err_q;

    case (state_q)
      S_IDLE: begin
        if (i_frame) begin
          state_d    = S_RECV;
          bit_cnt_d  = 3'd0;
          byte_idx_d = 16'd0;
          acc_d      = 16'd0;
          len_err_d  = 1'b0;
          // A strobe in the frame-start cycle is the packet's first bit.
          if (i_bit_valid) begin
            shift_d   = {6'd0, i_bit_data};
            bit_cnt_d = 3'd1;
          end
        end
      end

      S_RECV: begin
        if (!i_frame) begin
          // Frame ended early; any partial byte is dropped.
          done_d  = 1'b1;
          ok_d    = 1'b0;
          err_d   = 2'b11;
          state_d = S_IDLE;
        end else if (i_bit_valid) begin
          shift_d   = {shift_q[5:0], i_bit_data};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_d       = full_byte;
            byte_valid_d = 1'b1;
            byte_idx_d   = byte_idx_q + 16'd1;
            case (byte_idx_q)
              16'd0: src_d[15:8]  = full_byte;
              16'd1: src_d[7:0]   = full_byte;
              16'd2: dst_d[15:8]  = full_byte;
              16'd3: dst_d[7:0]   = full_byte;
              16'd4: len_d[15:8]  = full_byte;
              16'd5: len_d[7:0]   = full_byte;
              16'd6: csum_d[15:8] = full_byte;
              16'd7: csum_d[7:0]  = full_byte;
              default: ;
            endcase
            if (byte_idx_q == 16'd5 && (new_len < 16'd8 || new_len > MAX_LEN)) begin
              len_err_d = 1'b1;
              state_d   = S_DRAIN;
            end else begin
              if (!byte_idx_q[0]) hi_d = full_byte;
              if (byte_idx_q[0] || is_last) acc_d = acc_fold;
              if (is_last) begin
                byte_last_d = 1'b1;
                state_d     = S_CHECK;
              end
            end
          end
        end
      end

      S_CHECK: begin
        done_d = 1'b1;
        // A zero checksum field means the sender did not compute one.
        if (csum_q == 16'h0000 || acc_q == 16'hFFFF) begin
          ok_d  = 1'b1;
          err_d = 2'b00;
        end else begin
          ok_d  = 1'b0;
          err_d = 2'b01;
        end
        state_d = i_frame ? S_DRAIN : S_IDLE;
      end

      S_DRAIN: begin
        if (!i_frame) begin
          // Length errors report only once the frame has actually ended.
          if (len_err_q) begin
            done_d = 1'b1;
            ok_d   = 1'b0;
            err_d  = 2'b10;
          end
          len_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 7'd0;
      byte_idx_q   <= 16'd0;
      acc_q        <= 16'd0;
      hi_q         <= 8'd0;
      len_err_q    <= 1'b0;
      byte_q       <= 8'd0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      src_q        <= 16'd0;
      dst_q        <= 16'd0;
      len_q        <= 16'd0;
      csum_q       <= 16'd0;
      done_q       <= 1'b0;
      ok_q         <= 1'b0;
      err_q        <= 2'b00;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_idx_q   <= byte_idx_d;
      acc_q        <= acc_d;
      hi_q         <= hi_d;
      len_err_q    <= len_err_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      byte_last_q  <= byte_last_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      csum_q       <= csum_d;
      done_q       <= done_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
    end
  end

  assign o_byte        = byte_q;
  assign o_byte_valid  = byte_valid_q;
  assign o_byte_last   = byte_last_q;
  assign o_src_port    = src_q;
  assign o_dst_port    = dst_q;
  assign o_length      = len_q;
  assign o_rx_checksum = csum_q;
  assign o_pkt_done    = done_q;
  assign o_pkt_ok      = ok_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_udp_rx_framer.sv
// Directed bench for udp_rx_framer: good even/odd packets, bad checksum,
// disabled checksum, bad length, truncation and mid-packet reset.
module tb_udp_rx_framer;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_frame = 1'b0;
  logic        i_bit_valid = 1'b0;
  logic        i_bit_data = 1'b0;
  logic [7:0]  o_byte;
  logic        o_byte_valid, o_byte_last;
  logic [15:0] o_src_port, o_dst_port, o_length, o_rx_checksum;
  logic        o_pkt_done, o_pkt_ok;
  logic [1:0]  o_err;

  udp_rx_framer dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_frame(i_frame),
    .i_bit_valid(i_bit_valid), .i_bit_data(i_bit_data),
    .o_byte(o_byte), .o_byte_valid(o_byte_valid), .o_byte_last(o_byte_last),
    .o_src_port(o_src_port), .o_dst_port(o_dst_port), .o_length(o_length),
    .o_rx_checksum(o_rx_checksum), .o_pkt_done(o_pkt_done),
    .o_pkt_ok(o_pkt_ok), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         nbytes = 0, nlast = 0, ndone = 0;
  int         last_cyc = 0, done_cyc = 0;
  logic [7:0] last_byte = 8'h00;
  logic       done_ok = 1'b0;
  logic [1:0] done_err = 2'b00;
  logic [7:0] hist [64];

  always @(negedge i_clk) begin
    if (o_byte_valid) begin
      hist[nbytes % 64] <= o_byte;
      nbytes <= nbytes + 1;
      if (o_byte_last) begin
        nlast     <= nlast + 1;
        last_byte <= o_byte;
        last_cyc  <= cyc;
      end
    end
    if (o_pkt_done) begin
      ndone    <= ndone + 1;
      done_ok  <= o_pkt_ok;
      done_err <= o_err;
      done_cyc <= cyc;
    end
  end

  int total = 0, bad = 0;
  int last_bit_cyc = 0;
  logic [7:0] pkt_buf [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input int gap);
    i_bit_valid = 1'b1;
    i_bit_data  = b;
    step(1);
    last_bit_cyc = cyc;
    i_bit_valid = 1'b0;
    step(gap);
  endtask

  task automatic send_buf(input int n, input int gap);
    i_frame = 1'b1;
    for (int k = 0; k < n; k++)
      for (int i = 7; i >= 0; i--)
        send_bit(pkt_buf[k][i], gap);
  endtask

  task automatic end_frame();
    i_frame = 1'b0;
    i_bit_valid = 1'b0;
    step(3);
  endtask

  task automatic set_pkt1(input logic [15:0] cs);
    pkt_buf[0] = 8'h12; pkt_buf[1] = 8'h34; pkt_buf[2] = 8'h00; pkt_buf[3] = 8'h50;
    pkt_buf[4] = 8'h00; pkt_buf[5] = 8'h0A; pkt_buf[6] = cs[15:8]; pkt_buf[7] = cs[7:0];
    pkt_buf[8] = 8'hAB; pkt_buf[9] = 8'hCD;
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_byte"},  32'(o_byte), 32'h0);
    chk({tag, "_bv"},    32'(o_byte_valid), 32'h0);
    chk({tag, "_blast"}, 32'(o_byte_last), 32'h0);
    chk({tag, "_src"},   32'(o_src_port), 32'h0);
    chk({tag, "_dst"},   32'(o_dst_port), 32'h0);
    chk({tag, "_len"},   32'(o_length), 32'h0);
    chk({tag, "_csum"},  32'(o_rx_checksum), 32'h0);
    chk({tag, "_done"},  32'(o_pkt_done), 32'h0);
    chk({tag, "_ok"},    32'(o_pkt_ok), 32'h0);
    chk({tag, "_err"},   32'(o_err), 32'h0);
  endtask

  int b0, d0, l0, drop_cyc;

  initial begin
    // Reset state
    step(3);
    chk_cleared("rst");
    i_rst_n = 1'b1;
    step(2);

    // 1: even-length good packet, bits every cycle
    set_pkt1(16'h41A4);
    b0 = nbytes; d0 = ndone; l0 = nlast;
    send_buf(10, 0);
    step(3);
    chk("t1_nbytes", 32'(nbytes - b0), 32'd10);
    chk("t1_nlast", 32'(nlast - l0), 32'd1);
    chk("t1_lastbyte", 32'(last_byte), 32'hCD);
    chk("t1_last_lat", 32'(last_cyc), 32'(last_bit_cyc));
    chk("t1_done_lat", 32'(done_cyc), 32'(last_bit_cyc + 1));
    chk("t1_ok", 32'(done_ok), 32'd1);
    chk("t1_err", 32'(done_err), 32'd0);
    chk("t1_len", 32'(o_length), 32'h000A);
    chk("t1_src", 32'(o_src_port), 32'h1234);
    chk("t1_dst", 32'(o_dst_port), 32'h0050);
    chk("t1_csum", 32'(o_rx_checksum), 32'h41A4);
    for (int k = 0; k < 10; k++)
      chk("t1_bytes", 32'(hist[(b0 + k) % 64]), 32'(pkt_buf[k]));
    end_frame();
    chk("t1_ndone", 32'(ndone - d0), 32'd1);
    $display("pkt1 even good: bytes=%0d ok=%0d err=%0d", nbytes - b0, done_ok, done_err);

    // 2: odd-length good packet, 3-cycle gaps between bit strobes
    pkt_buf[0] = 8'h12; pkt_buf[1] = 8'h34; pkt_buf[2] = 8'h00; pkt_buf[3] = 8'h50;
    pkt_buf[4] = 8'h00; pkt_buf[5] = 8'h09; pkt_buf[6] = 8'h42; pkt_buf[7] = 8'h72;
    pkt_buf[8] = 8'hAB;
    b0 = nbytes; d0 = ndone;
    send_buf(9, 3);
    end_frame();
    chk("t2_nbytes", 32'(nbytes - b0), 32'd9);
    chk("t2_lastbyte", 32'(last_byte), 32'hAB);
    chk("t2_ndone", 32'(ndone - d0), 32'd1);
    chk("t2_ok", 32'(done_ok), 32'd1);
    chk("t2_err", 32'(done_err), 32'd0);
    chk("t2_len", 32'(o_length), 32'h0009);
    $display("pkt2 odd good: bytes=%0d ok=%0d err=%0d", nbytes - b0, done_ok, done_err);

    // 3: bad checksum
    set_pkt1(16'h41A5);
    d0 = ndone;
    send_buf(10, 0);
    end_frame();
    chk("t3_ndone", 32'(ndone - d0), 32'd1);
    chk("t3_ok", 32'(done_ok), 32'd0);
    chk("t3_err", 32'(done_err), 32'd1);
    chk("t3_err_held", 32'(o_err), 32'd1);
    $display("pkt3 bad csum: ok=%0d err=%0d", done_ok, done_err);

    // 4: checksum disabled
    set_pkt1(16'h0000);
    d0 = ndone;
    send_buf(10, 0);
    end_frame();
    chk("t4_ndone", 32'(ndone - d0), 32'd1);
    chk("t4_ok", 32'(done_ok), 32'd1);
    chk("t4_err", 32'(done_err), 32'd0);
    chk("t4_csum", 32'(o_rx_checksum), 32'h0);
    $display("pkt4 csum off: ok=%0d err=%0d", done_ok, done_err);

    // 5: bad length, frame stays up for 20 more bytes
    pkt_buf[0] = 8'h12; pkt_buf[1] = 8'h34; pkt_buf[2] = 8'h00; pkt_buf[3] = 8'h50;
    pkt_buf[4] = 8'h00; pkt_buf[5] = 8'h04;
    for (int k = 6; k < 26; k++) pkt_buf[k] = 8'h5A;
    b0 = nbytes; d0 = ndone;
    send_buf(26, 0);
    step(2);
    chk("t5_nbytes", 32'(nbytes - b0), 32'd6);
    chk("t5_nodone_early", 32'(ndone - d0), 32'd0);
    i_frame = 1'b0;
    step(1);
    drop_cyc = cyc;
    step(3);
    chk("t5_ndone", 32'(ndone - d0), 32'd1);
    chk("t5_done_lat", 32'(done_cyc), 32'(drop_cyc));
    chk("t5_ok", 32'(done_ok), 32'd0);
    chk("t5_err", 32'(done_err), 32'd2);
    chk("t5_len", 32'(o_length), 32'h0004);
    $display("pkt5 bad length: bytes=%0d ok=%0d err=%0d", nbytes - b0, done_ok, done_err);

    // 6: truncation after 6 bytes + 3 bits
    set_pkt1(16'h41A4);
    b0 = nbytes; d0 = ndone;
    send_buf(6, 0);
    send_bit(1'b1, 0); send_bit(1'b0, 0); send_bit(1'b1, 0);
    i_frame = 1'b0;
    step(1);
    drop_cyc = cyc;
    step(3);
    chk("t6_nbytes", 32'(nbytes - b0), 32'd6);
    chk("t6_ndone", 32'(ndone - d0), 32'd1);
    chk("t6_done_lat", 32'(done_cyc), 32'(drop_cyc));
    chk("t6_ok", 32'(done_ok), 32'd0);
    chk("t6_err", 32'(done_err), 32'd3);
    $display("pkt6 truncated: bytes=%0d ok=%0d err=%0d", nbytes - b0, done_ok, done_err);

    // 7: reset mid-packet, then a good packet
    set_pkt1(16'h41A4);
    d0 = ndone;
    send_buf(4, 0);
    send_bit(1'b0, 0); send_bit(1'b1, 0);
    i_rst_n = 1'b0;
    i_frame = 1'b0;
    #2;
    chk_cleared("t7_rst");
    step(2);
    i_rst_n = 1'b1;
    step(3);
    chk("t7_nodone", 32'(ndone - d0), 32'd0);
    b0 = nbytes;
    send_buf(10, 0);
    end_frame();
    chk("t7_nbytes", 32'(nbytes - b0), 32'd10);
    chk("t7_ndone", 32'(ndone - d0), 32'd1);
    chk("t7_ok", 32'(done_ok), 32'd1);
    chk("t7_err", 32'(done_err), 32'd0);
    $display("pkt7 after reset: bytes=%0d ok=%0d err=%0d", nbytes - b0, done_ok, done_err);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
